// File: rtl/key_gear_ctrl.sv
// Rider control panel front end: synchronises and debounces six active-low keys and
// turns them into registered speed-trim pulses, a saturating gear select and a direction level.
module key_gear_ctrl #(
    parameter int DEB_CYCLES   = 50000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_up_n,
    input  logic       key_down_n,
    input  logic       key_gup_n,
    input  logic       key_gdn_n,
    input  logic       key_dir_n,
    input  logic       key_stop_n,
    output logic       up,
    output logic       down,
    output logic [1:0] division,
    output logic       direction,
    output logic       dir_reject
);

    localparam int NK     = 6;
    localparam int K_UP   = 0;
    localparam int K_DN   = 1;
    localparam int K_GUP  = 2;
    localparam int K_GDN  = 3;
    localparam int K_DIR  = 4;
    localparam int K_STOP = 5;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [NK-1:0]            keys_n;
    logic [NK-1:0]            sync1;
    logic [NK-1:0]            sync2;
    logic [NK-1:0]            stable;
    logic [NK-1:0]            armed;
    logic [NK-1:0]            press;
    logic [1:0]               sync_valid;
    logic [NK-1:0][CNT_W-1:0] deb_cnt;

    assign keys_n = {key_stop_n, key_dir_n, key_gdn_n, key_gup_n, key_down_n, key_up_n};

    // A key only produces a press after it has been seen released since reset, so a
    // key held through reset stays silent until it is let go and pressed again.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= '1;
            sync2      <= '1;
            stable     <= '1;
            armed      <= '0;
            press      <= '0;
            sync_valid <= '0;
            deb_cnt    <= '0;
        end else begin
            sync1      <= keys_n;
            sync2      <= sync1;
            sync_valid <= {sync_valid[0], 1'b1};
            if (sync_valid[1]) begin
                armed <= armed | sync2;
            end
            for (int i = 0; i < NK; i++) begin
                press[i] <= armed[i] & stable[i] & ~sync2[i] & (deb_cnt[i] == DEB_LAST);
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Repeat engines: index 0 serves the up key, index 1 the down key.
    logic [1:0][1:0]       rep_state;
    logic [1:0][1:0]       rep_state_nxt;
    logic [1:0][CNT_W-1:0] rep_cnt;
    logic [1:0][CNT_W-1:0] rep_cnt_nxt;
    logic [1:0]            fire;
    logic [1:0]            held;
    logic                  both_held;
    logic                  both_press;
    logic                  stop_ev;

    assign held       = ~stable[K_DN:K_UP];
    assign both_held  = held[0] & held[1];
    assign both_press = press[K_UP] & press[K_DN];
    assign stop_ev    = press[K_STOP];

    always_comb begin
        rep_state_nxt = rep_state;
        rep_cnt_nxt   = rep_cnt;
        fire          = '0;
        for (int i = 0; i < 2; i++) begin
            if (stop_ev || !held[i]) begin
                rep_state_nxt[i] = ST_IDLE;
                rep_cnt_nxt[i]   = '0;
            end else begin
                case (rep_state[i])
                    ST_IDLE: begin
                        if (press[i] && !both_press) begin
                            fire[i]          = 1'b1;
                            rep_cnt_nxt[i]   = '0;
                            rep_state_nxt[i] = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (rep_cnt[i] == DELAY_LAST) begin
                            fire[i]          = ~both_held;
                            rep_cnt_nxt[i]   = '0;
                            rep_state_nxt[i] = ST_REPEAT;
                        end else begin
                            rep_cnt_nxt[i] = rep_cnt[i] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (rep_cnt[i] == RATE_LAST) begin
                            fire[i]        = ~both_held;
                            rep_cnt_nxt[i] = '0;
                        end else begin
                            rep_cnt_nxt[i] = rep_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        rep_state_nxt[i] = ST_IDLE;
                        rep_cnt_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Direction decisions look at the gear value before this cycle's gear update.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_state  <= {ST_IDLE, ST_IDLE};
            rep_cnt    <= '0;
            up         <= 1'b0;
            down       <= 1'b0;
            division   <= 2'd0;
            direction  <= 1'b1;
            dir_reject <= 1'b0;
        end else begin
            rep_state  <= rep_state_nxt;
            rep_cnt    <= rep_cnt_nxt;
            up         <= fire[0] & ~fire[1];
            down       <= fire[1] & ~fire[0];
            dir_reject <= 1'b0;
            if (stop_ev) begin
                division <= 2'd0;
            end else begin
                if (press[K_DIR]) begin
                    if (division == 2'd0) begin
                        direction <= ~direction;
                    end else begin
                        dir_reject <= 1'b1;
                    end
                end
                if (press[K_GUP] && !press[K_GDN] && division != 2'd3) begin
                    division <= division + 2'd1;
                end else if (press[K_GDN] && !press[K_GUP] && division != 2'd0) begin
                    division <= division - 2'd1;
                end
            end
        end
    end

endmodule
